// File: rtl/flash_rd_ctrl_pkg.sv
// Shared definitions for the flash line-fill read controller: FSM encoding,
// burst geometry and address widths.
package flash_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  localparam int LINE_BEATS = 4;
  localparam int BYTE_AW    = 20;
  localparam int WORD_AW    = 18;
  localparam int BASE_W     = BYTE_AW - 4;
  localparam int BEAT_W     = 2;
  localparam int WAIT_W     = 4;
  localparam int DATA_W     = 32;

  // Flash word address of beat k within the line at base.
  function automatic logic [WORD_AW-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                   input logic [BEAT_W-1:0] k);
    return {base, k};
  endfunction

endpackage

// File: rtl/flash_rd_ctrl.sv
// Flash line-fill read controller: fetches a 4-word line in ascending order,
// holding each flash address for WAIT_CYC+1 cycles before capturing the word.
module flash_rd_ctrl
  import flash_rd_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = 2,
  parameter int BEATS    = LINE_BEATS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic [BYTE_AW-1:0] c_addr,
  output logic               ack,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  output logic               f_rd,
  output logic [WORD_AW-1:0] f_addr,
  input  logic [DATA_W-1:0]  f_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_CYC);
  localparam logic [BEAT_W-1:0] LAST_K   = BEAT_W'(BEATS - 1);

  state_e              state_q,  state_d;
  logic [BASE_W-1:0]   base_q,   base_d;
  logic [BEAT_W-1:0]   k_q,      k_d;
  logic [WAIT_W-1:0]   wcnt_q,   wcnt_d;
  logic                ack_q,    ack_d;
  logic                valid_q,  valid_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic                f_rd_q,   f_rd_d;
  logic [WORD_AW-1:0]  f_addr_q, f_addr_d;
  logic                beat_done;

  // Byte offset within the line never reaches the flash.
  logic unused_offset;
  assign unused_offset = ^c_addr[3:0];

  assign beat_done = (wcnt_q == WAIT_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      k_q      <= '0;
      wcnt_q   <= '0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      f_rd_q   <= 1'b0;
      f_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      f_rd_q   <= f_rd_d;
      f_addr_q <= f_addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    ack_d    = 1'b0;
    valid_d  = 1'b0;
    data_d   = data_q;
    f_rd_d   = f_rd_q;
    f_addr_d = f_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        f_rd_d = 1'b0;
        if (req) begin
          base_d   = c_addr[BYTE_AW-1:4];
          k_d      = '0;
          wcnt_d   = '0;
          ack_d    = 1'b1;
          f_rd_d   = 1'b1;
          f_addr_d = word_addr(c_addr[BYTE_AW-1:4], '0);
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        if (beat_done) begin
          data_d  = f_rdata;
          valid_d = 1'b1;
          wcnt_d  = '0;
          if (k_q == LAST_K) begin
            // k stays at the final beat until the line completes.
            f_rd_d  = 1'b0;
            state_d = ST_LAST;
          end else begin
            k_d      = k_q + 2'd1;
            f_addr_d = word_addr(base_q, k_q + 2'd1);
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      ST_LAST: begin
        k_d     = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        f_rd_d  = 1'b0;
      end
    endcase
  end

  assign ack    = ack_q;
  assign valid  = valid_q;
  assign data   = data_q;
  assign f_rd   = f_rd_q;
  assign f_addr = f_addr_q;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Bench for flash_rd_ctrl: one instance at WAIT_CYC=2 and one at WAIT_CYC=0,
// each with a flash model that only returns the right word after the wait window.
module tb_flash_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, b_req;
  logic [19:0] a_c_addr, b_c_addr;
  logic        a_ack, b_ack, a_valid, b_valid, a_f_rd, b_f_rd;
  logic [31:0] a_data, b_data, a_f_rdata, b_f_rdata;
  logic [17:0] a_f_addr, b_f_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_rd_ctrl #(.WAIT_CYC(2), .BEATS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(a_req), .c_addr(a_c_addr),
    .ack(a_ack), .valid(a_valid), .data(a_data),
    .f_rd(a_f_rd), .f_addr(a_f_addr), .f_rdata(a_f_rdata)
  );

  flash_rd_ctrl #(.WAIT_CYC(0), .BEATS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(b_req), .c_addr(b_c_addr),
    .ack(b_ack), .valid(b_valid), .data(b_data),
    .f_rd(b_f_rd), .f_addr(b_f_addr), .f_rdata(b_f_rdata)
  );

  function automatic logic [31:0] fword(input logic [17:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // Flash model: word is only correct once the address has been stable long enough.
  logic [17:0] a_last;
  int          a_stab = 0;
  always @(negedge clk) begin
    if (a_f_addr == a_last) a_stab <= a_stab + 1;
    else a_stab <= 0;
    a_last <= a_f_addr;
  end
  assign a_f_rdata = (a_f_rd && a_stab >= 2) ? fword(a_f_addr) : 32'hBAD0BAD0;
  assign b_f_rdata = b_f_rd ? fword(b_f_addr) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboards: four words pushed per accepted request, popped per valid.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [19:0] a_cprev, b_cprev;
  int a_acks = 0, a_vlds = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      q_a.delete();
      a_acks = 0;
      a_vlds = 0;
    end else begin
      if (a_ack) begin
        total++;
        if (q_a.size() != 0) begin
          bad++;
          $display("FAIL sb_a_ack: ack with %0d words pending, want 0", q_a.size());
        end
        a_acks++;
        for (int k = 0; k < 4; k++) q_a.push_back(fword({a_cprev[19:4], 2'(k)}));
      end
      if (a_valid) begin
        a_vlds++;
        total++;
        if (q_a.size() == 0) begin
          bad++;
          $display("FAIL sb_a_valid: valid data %h with nothing expected", a_data);
        end else begin
          logic [31:0] e;
          e = q_a.pop_front();
          if (a_data !== e) begin
            bad++;
            $display("FAIL sb_a_data: got %h want %h", a_data, e);
          end
        end
      end
    end
    a_cprev = a_c_addr;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q_b.delete();
    end else begin
      if (b_ack)
        for (int k = 0; k < 4; k++) q_b.push_back(fword({b_cprev[19:4], 2'(k)}));
      if (b_valid) begin
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL sb_b_valid: valid data %h with nothing expected", b_data);
        end else begin
          logic [31:0] e;
          e = q_b.pop_front();
          if (b_data !== e) begin
            bad++;
            $display("FAIL sb_b_data: got %h want %h", b_data, e);
          end
        end
      end
    end
    b_cprev = b_c_addr;
  end

  typedef struct {
    bit          sel;    // 0: WAIT_CYC=2 instance, 1: WAIT_CYC=0 instance
    bit          req;
    logic [19:0] caddr;
    logic [20:0] exp;    // {ack, valid, f_rd, f_addr}
  } vec_t;

  function automatic vec_t mk(input bit s, input bit r, input logic [19:0] ca,
                              input bit ak, input bit vl, input bit rd, input logic [17:0] fa);
    vec_t v;
    v.sel = s; v.req = r; v.caddr = ca; v.exp = {ak, vl, rd, fa};
    return v;
  endfunction

  task automatic cyc_a(input logic r, input logic [19:0] ca);
    @(posedge clk); #1;
    a_req = r; a_c_addr = ca;
    @(negedge clk);
  endtask

  vec_t vt[22];
  int   n_ack, n_vld;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; a_c_addr = '0;
    b_req = 1'b0; b_c_addr = '0;

    vt[0]  = mk(0, 1, 20'h00120, 0, 0, 0, 18'h00000);
    vt[1]  = mk(0, 0, 20'h00000, 1, 0, 1, 18'h00048);
    vt[2]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h00048);
    vt[3]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h00048);
    vt[4]  = mk(0, 0, 20'h00000, 0, 1, 1, 18'h00049);
    vt[5]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h00049);
    vt[6]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h00049);
    vt[7]  = mk(0, 0, 20'h00000, 0, 1, 1, 18'h0004A);
    vt[8]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h0004A);
    vt[9]  = mk(0, 0, 20'h00000, 0, 0, 1, 18'h0004A);
    vt[10] = mk(0, 0, 20'h00000, 0, 1, 1, 18'h0004B);
    vt[11] = mk(0, 0, 20'h00000, 0, 0, 1, 18'h0004B);
    vt[12] = mk(0, 0, 20'h00000, 0, 0, 1, 18'h0004B);
    vt[13] = mk(0, 0, 20'h00000, 0, 1, 0, 18'h0004B);
    vt[14] = mk(0, 0, 20'h00000, 0, 0, 0, 18'h0004B);
    vt[15] = mk(1, 1, 20'hFFFF7, 0, 0, 0, 18'h00000);
    vt[16] = mk(1, 0, 20'h00000, 1, 0, 1, 18'h3FFFC);
    vt[17] = mk(1, 0, 20'h00000, 0, 1, 1, 18'h3FFFD);
    vt[18] = mk(1, 0, 20'h00000, 0, 1, 1, 18'h3FFFE);
    vt[19] = mk(1, 0, 20'h00000, 0, 1, 1, 18'h3FFFF);
    vt[20] = mk(1, 0, 20'h00000, 0, 1, 0, 18'h3FFFF);
    vt[21] = mk(1, 0, 20'h00000, 0, 0, 0, 18'h3FFFF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {a_ack, a_valid, a_f_rd, a_f_addr, a_data}, '0);
    chk("reset_b", {b_ack, b_valid, b_f_rd, b_f_addr, b_data}, '0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      a_req = vt[i].sel ? 1'b0 : vt[i].req;
      b_req = vt[i].sel ? vt[i].req : 1'b0;
      a_c_addr = vt[i].sel ? 20'h0 : vt[i].caddr;
      b_c_addr = vt[i].sel ? vt[i].caddr : 20'h0;
      @(negedge clk);
      if (vt[i].sel) chk($sformatf("vec%0d_b", i), {b_ack, b_valid, b_f_rd, b_f_addr}, vt[i].exp);
      else           chk($sformatf("vec%0d_a", i), {a_ack, a_valid, a_f_rd, a_f_addr}, vt[i].exp);
    end
    b_req = 1'b0;

    // req held high: second burst only after an IDLE cycle
    n_ack = 0; n_vld = 0;
    for (int c = 0; c < 16; c++) begin
      cyc_a(1'b1, 20'h33330);
      if (a_ack) n_ack++;
      if (a_valid && c < 15) n_vld++;
      if (c == 1)  chk("hold_ack_c1", a_ack, 1);
      if (c == 14) chk("hold_idle_c14", {a_ack, a_f_rd}, 0);
      if (c == 15) chk("hold_ack_c15", a_ack, 1);
    end
    chk("hold_ack_count", n_ack, 2);
    chk("hold_valid_count", n_vld, 4);
    for (int c = 0; c < 16; c++) cyc_a(1'b0, 20'h0);

    // c_addr wanders and req is asserted while the burst is busy
    n_ack = 0;
    cyc_a(1'b1, 20'h5A5A0);
    for (int c = 1; c < 15; c++) begin
      cyc_a((c >= 2 && c <= 13), $urandom());
      if (c >= 2 && a_ack) n_ack++;
      if (c == 1)  chk("latch_fa_k0", a_f_addr, 18'h16968);
      if (c == 4)  chk("latch_fa_k1", a_f_addr, 18'h16969);
      if (c == 10) chk("latch_fa_k3", a_f_addr, 18'h1696B);
    end
    chk("busy_req_ignored", n_ack, 0);
    repeat (2) cyc_a(1'b0, 20'h0);

    // reset asserted mid-burst
    cyc_a(1'b1, 20'h0ABC0);
    for (int c = 1; c < 5; c++) cyc_a(1'b0, 20'h0);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 chk("midreset_outputs", {a_ack, a_valid, a_f_rd, a_f_addr, a_data}, '0);
    @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    n_vld = 0;
    for (int c = 7; c < 15; c++) begin
      cyc_a(1'b0, 20'h0);
      if (a_valid) n_vld++;
    end
    chk("midreset_no_valid", n_vld, 0);
    cyc_a(1'b1, 20'h0DEF0);
    cyc_a(1'b0, 20'h0);
    chk("postreset_ack", {a_ack, a_f_addr}, {1'b1, 18'h037BC});
    n_vld = 0;
    for (int c = 2; c < 16; c++) begin
      cyc_a(1'b0, 20'h0);
      if (a_valid) n_vld++;
    end
    chk("postreset_valids", n_vld, 4);

    // randomized traffic, scoreboard checks each word
    for (int c = 0; c < 400; c++) cyc_a($urandom_range(0, 3) == 0, $urandom());
    for (int c = 0; c < 20; c++) cyc_a(1'b0, 20'h0);
    chk("rand_queue_empty", q_a.size(), 0);
    chk("rand_valid_eq_4ack", a_vlds, 4 * a_acks);
    chk("rand_some_acks", (a_acks > 5), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
